// File: rtl/cmd_dispatch_scheduler.sv
// cmd_dispatch_scheduler
//
// Buffers decoded commands from the fetch unit in an in-order FIFO and issues
// the head to either the DMA engine (LOAD/STORE) or the NTT compute engine.
// A head whose slot is still owned by an in-flight operation stalls the queue
// until the matching done pulse frees the slot.
//
// Ports:
//   clk, rst_n                  clock, async active-low reset
//   in_valid/in_ready/in_*      command push from fetch (opcode, slot, addr)
//   dma_valid/dma_ready/dma_*   DMA command output register
//   dma_done, dma_done_slot     DMA completion pulse and its slot
//   cmp_valid/cmp_ready/cmp_*   compute command output register
//   cmp_done, cmp_done_slot     compute completion pulse and its slot
//   slot_busy                   in-flight slot bitmap
//   idle                        nothing queued, issued or in flight
//   err_illegal                 sticky flag: an illegal opcode was dropped
module cmd_dispatch_scheduler #(
  parameter int FIFO_DEPTH = 4,
  parameter int ADDR_W     = 48
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [7:0]        in_opcode,
  input  logic [3:0]        in_slot,
  input  logic [ADDR_W-1:0] in_addr,
  output logic              dma_valid,
  input  logic              dma_ready,
  output logic [7:0]        dma_opcode,
  output logic [3:0]        dma_slot,
  output logic [ADDR_W-1:0] dma_addr,
  input  logic              dma_done,
  input  logic [3:0]        dma_done_slot,
  output logic              cmp_valid,
  input  logic              cmp_ready,
  output logic [7:0]        cmp_opcode,
  output logic [3:0]        cmp_slot,
  input  logic              cmp_done,
  input  logic [3:0]        cmp_done_slot,
  output logic [15:0]       slot_busy,
  output logic              idle,
  output logic              err_illegal
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [PTR_W:0] DEPTH_CNT = (PTR_W+1)'(FIFO_DEPTH);

  typedef struct packed {
    logic [7:0]        opcode;
    logic [3:0]        slot;
    logic [ADDR_W-1:0] addr;
  } cmd_t;

  typedef enum logic [1:0] {
    TGT_ILLEGAL = 2'd0,
    TGT_DMA     = 2'd1,
    TGT_CMP     = 2'd2
  } tgt_e;

  function automatic tgt_e decode(input logic [7:0] op);
    if (op == 8'h01 || op == 8'h02) return TGT_DMA;
    if (op[7:4] == 4'h1)            return TGT_CMP;
    return TGT_ILLEGAL;
  endfunction

  // ---------------------------------------------------------------- FIFO
  cmd_t             mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [PTR_W:0]   count;
  logic             full, empty, push, pop;
  cmd_t             in_cmd, head;

  assign full     = (count == DEPTH_CNT);
  assign empty    = (count == '0);
  assign in_ready = !full;
  // in_ready already excludes full, so a push never overwrites a live entry
  // even when the head pops in the same cycle.
  assign push     = in_valid && in_ready;
  assign in_cmd   = '{opcode: in_opcode, slot: in_slot, addr: in_addr};
  assign head     = mem[rd_ptr];

  // Storage needs no reset: entries are only read while count says they are live.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= in_cmd;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + (PTR_W+1)'(push) - (PTR_W+1)'(pop);
    end
  end

  // ---------------------------------------------------------- issue logic
  tgt_e        head_tgt;
  logic [15:0] done_clr, set_mask, busy_after_done;
  logic        dma_free, cmp_free, slot_free;
  logic        issue_dma, issue_cmp, drop;

  assign head_tgt = decode(head.opcode);

  // Done pulses are applied before the hazard check so a head waiting on a
  // slot can issue on the very edge its done is sampled. Two pulses on the
  // same slot just clear the same bit; done on an idle slot is a no-op.
  always_comb begin
    done_clr = '0;
    if (dma_done) done_clr = done_clr | (16'h0001 << dma_done_slot);
    if (cmp_done) done_clr = done_clr | (16'h0001 << cmp_done_slot);
  end
  assign busy_after_done = slot_busy & ~done_clr;
  assign slot_free       = !busy_after_done[head.slot];

  // An output register can take a new command if empty or draining this edge.
  assign dma_free = !dma_valid || dma_ready;
  assign cmp_free = !cmp_valid || cmp_ready;

  assign issue_dma = !empty && (head_tgt == TGT_DMA) && slot_free && dma_free;
  assign issue_cmp = !empty && (head_tgt == TGT_CMP) && slot_free && cmp_free;
  // Illegal heads are discarded without looking at slot state so they never
  // stall the queue.
  assign drop      = !empty && (head_tgt == TGT_ILLEGAL);
  assign pop       = issue_dma || issue_cmp || drop;

  // The issue's set is OR'ed in after the done-clear, so a simultaneous
  // done and re-issue on one slot leaves it owned by the new command.
  assign set_mask = (issue_dma || issue_cmp) ? (16'h0001 << head.slot) : 16'h0000;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot_busy   <= '0;
      err_illegal <= 1'b0;
    end else begin
      slot_busy <= busy_after_done | set_mask;
      if (drop) err_illegal <= 1'b1;
    end
  end

  // ------------------------------------------------------ output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dma_valid  <= 1'b0;
      dma_opcode <= '0;
      dma_slot   <= '0;
      dma_addr   <= '0;
    end else if (issue_dma) begin
      dma_valid  <= 1'b1;
      dma_opcode <= head.opcode;
      dma_slot   <= head.slot;
      dma_addr   <= head.addr;
    end else if (dma_valid && dma_ready) begin
      dma_valid  <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cmp_valid  <= 1'b0;
      cmp_opcode <= '0;
      cmp_slot   <= '0;
    end else if (issue_cmp) begin
      cmp_valid  <= 1'b1;
      cmp_opcode <= head.opcode;
      cmp_slot   <= head.slot;
    end else if (cmp_valid && cmp_ready) begin
      cmp_valid  <= 1'b0;
    end
  end

  assign idle = empty && !dma_valid && !cmp_valid && (slot_busy == '0);

endmodule

// File: tb/tb_cmd_dispatch_scheduler.sv
module tb_cmd_dispatch_scheduler;
  localparam int ADDR_W = 48;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              in_valid;
  logic              in_ready;
  logic [7:0]        in_opcode;
  logic [3:0]        in_slot;
  logic [ADDR_W-1:0] in_addr;
  logic              dma_valid, dma_ready;
  logic [7:0]        dma_opcode;
  logic [3:0]        dma_slot;
  logic [ADDR_W-1:0] dma_addr;
  logic              dma_done;
  logic [3:0]        dma_done_slot;
  logic              cmp_valid, cmp_ready;
  logic [7:0]        cmp_opcode;
  logic [3:0]        cmp_slot;
  logic              cmp_done;
  logic [3:0]        cmp_done_slot;
  logic [15:0]       slot_busy;
  logic              idle, err_illegal;

  int passed = 0;
  int total  = 0;

  cmd_dispatch_scheduler #(.FIFO_DEPTH(4), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_opcode(in_opcode),
    .in_slot(in_slot), .in_addr(in_addr),
    .dma_valid(dma_valid), .dma_ready(dma_ready), .dma_opcode(dma_opcode),
    .dma_slot(dma_slot), .dma_addr(dma_addr),
    .dma_done(dma_done), .dma_done_slot(dma_done_slot),
    .cmp_valid(cmp_valid), .cmp_ready(cmp_ready), .cmp_opcode(cmp_opcode),
    .cmp_slot(cmp_slot),
    .cmp_done(cmp_done), .cmp_done_slot(cmp_done_slot),
    .slot_busy(slot_busy), .idle(idle), .err_illegal(err_illegal)
  );

  always #5 clk = ~clk;

  // Advance one edge; inputs change and outputs are sampled 1ns after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input logic v, input logic [7:0] op, input logic [3:0] s,
                        input logic [ADDR_W-1:0] a);
    in_valid  = v;
    in_opcode = op;
    in_slot   = s;
    in_addr   = a;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    set_in(1'b0, 8'h00, 4'h0, '0);
    dma_ready = 1'b0; cmp_ready = 1'b0;
    dma_done = 1'b0; dma_done_slot = 4'h0;
    cmp_done = 1'b0; cmp_done_slot = 4'h0;
    tick(); tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    do_reset();
    total++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready got %b want 1", in_ready); else passed++;
    total++; if (idle !== 1'b1) $display("FAIL reset_idle got %b want 1", idle); else passed++;
    total++; if ({dma_valid, cmp_valid} !== 2'b00) $display("FAIL reset_valids got %b want 00", {dma_valid, cmp_valid}); else passed++;
    total++; if (slot_busy !== 16'h0) $display("FAIL reset_slot_busy got %h want 0000", slot_busy); else passed++;
    total++; if (err_illegal !== 1'b0) $display("FAIL reset_err got %b want 0", err_illegal); else passed++;
    total++; if (dma_addr !== '0) $display("FAIL reset_dma_addr got %h want 0", dma_addr); else passed++;
  endtask

  task automatic test_basic_load();
    dma_ready = 1'b1;
    set_in(1'b1, 8'h01, 4'd3, 48'h1000);
    tick();                               // push edge N
    set_in(1'b0, 8'h00, 4'd0, '0);
    total++; if (dma_valid !== 1'b0) $display("FAIL basic_not_early got %b want 0", dma_valid); else passed++;
    tick();                               // issue edge N+1
    total++; if (dma_valid !== 1'b1) $display("FAIL basic_valid got %b want 1", dma_valid); else passed++;
    total++; if (dma_slot !== 4'd3) $display("FAIL basic_slot got %0d want 3", dma_slot); else passed++;
    total++; if (dma_addr !== 48'h1000) $display("FAIL basic_addr got %h want 1000", dma_addr); else passed++;
    total++; if (dma_opcode !== 8'h01) $display("FAIL basic_opcode got %h want 01", dma_opcode); else passed++;
    total++; if (slot_busy !== 16'h0008) $display("FAIL basic_busy got %h want 0008", slot_busy); else passed++;
    total++; if (idle !== 1'b0) $display("FAIL basic_not_idle got %b want 0", idle); else passed++;
    dma_done = 1'b1; dma_done_slot = 4'd3;
    tick();                               // accept + done
    dma_done = 1'b0;
    total++; if (slot_busy !== 16'h0) $display("FAIL basic_busy_clr got %h want 0000", slot_busy); else passed++;
    total++; if (dma_valid !== 1'b0) $display("FAIL basic_valid_drop got %b want 0", dma_valid); else passed++;
    total++; if (idle !== 1'b1) $display("FAIL basic_idle got %b want 1", idle); else passed++;
  endtask

  task automatic test_in_order();
    dma_ready = 1'b1; cmp_ready = 1'b1;
    set_in(1'b1, 8'h01, 4'd2, 48'h2000); tick();
    set_in(1'b1, 8'h10, 4'd2, 48'h0);    tick();   // LOAD s2 issues here
    set_in(1'b1, 8'h01, 4'd5, 48'h5000); tick();   // LOAD s2 accepted
    set_in(1'b0, 8'h00, 4'd0, '0);
    tick(); tick();
    total++; if (cmp_valid !== 1'b0) $display("FAIL order_ntt_held got %b want 0", cmp_valid); else passed++;
    total++; if (dma_valid !== 1'b0) $display("FAIL order_load5_held got %b want 0", dma_valid); else passed++;
    total++; if (slot_busy !== 16'h0004) $display("FAIL order_busy got %h want 0004", slot_busy); else passed++;
    dma_done = 1'b1; dma_done_slot = 4'd2;
    tick();                                         // NTT issues on the done edge
    dma_done = 1'b0;
    total++; if (cmp_valid !== 1'b1) $display("FAIL order_bypass_valid got %b want 1", cmp_valid); else passed++;
    total++; if ({cmp_opcode, cmp_slot} !== {8'h10, 4'd2}) $display("FAIL order_bypass_cmd got %h want 102", {cmp_opcode, cmp_slot}); else passed++;
    total++; if (slot_busy !== 16'h0004) $display("FAIL order_set_wins got %h want 0004", slot_busy); else passed++;
    total++; if (dma_valid !== 1'b0) $display("FAIL order_load5_still_held got %b want 0", dma_valid); else passed++;
    tick();
    total++; if (dma_valid !== 1'b1 || dma_slot !== 4'd5) $display("FAIL order_load5 got v=%b s=%0d want v=1 s=5", dma_valid, dma_slot); else passed++;
    total++; if (slot_busy !== 16'h0024) $display("FAIL order_busy2 got %h want 0024", slot_busy); else passed++;
    total++; if (cmp_valid !== 1'b0) $display("FAIL order_cmp_drop got %b want 0", cmp_valid); else passed++;
    dma_done = 1'b1; dma_done_slot = 4'd5;
    cmp_done = 1'b1; cmp_done_slot = 4'd2;
    tick();
    dma_done = 1'b0; cmp_done = 1'b0;
    total++; if (idle !== 1'b1 || slot_busy !== 16'h0) $display("FAIL order_idle got idle=%b busy=%h want 1/0000", idle, slot_busy); else passed++;
  endtask

  task automatic test_back_to_back();
    cmp_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      set_in(1'b1, 8'h11 + 8'(i), 4'(8 + i), '0);
      tick();
      if (i == 3) begin
        total++; if (in_ready !== 1'b1) $display("FAIL b2b_ready_before_full got %b want 1", in_ready); else passed++;
      end
    end
    set_in(1'b0, 8'h00, 4'd0, '0);
    total++; if (in_ready !== 1'b0) $display("FAIL b2b_full got %b want 0", in_ready); else passed++;
    total++; if (cmp_valid !== 1'b1 || cmp_slot !== 4'd8) $display("FAIL b2b_first got v=%b s=%0d want v=1 s=8", cmp_valid, cmp_slot); else passed++;
    tick();
    total++; if (in_ready !== 1'b0) $display("FAIL b2b_stall_holds got %b want 0", in_ready); else passed++;
    total++; if (cmp_slot !== 4'd8) $display("FAIL b2b_stable got %0d want 8", cmp_slot); else passed++;
    cmp_ready = 1'b1;
    for (int i = 1; i < 5; i++) begin
      tick();
      total++;
      if (cmp_valid !== 1'b1 || cmp_slot !== 4'(8 + i) || cmp_opcode !== 8'h11 + 8'(i))
        $display("FAIL b2b_drain%0d got v=%b s=%0d op=%h want v=1 s=%0d op=%h",
                 i, cmp_valid, cmp_slot, cmp_opcode, 8 + i, 8'h11 + 8'(i));
      else passed++;
    end
    tick();
    total++; if (cmp_valid !== 1'b0) $display("FAIL b2b_empty got %b want 0", cmp_valid); else passed++;
    total++; if (slot_busy !== 16'h1F00) $display("FAIL b2b_busy got %h want 1f00", slot_busy); else passed++;
    for (int i = 8; i < 13; i++) begin
      cmp_done = 1'b1; cmp_done_slot = 4'(i);
      tick();
    end
    cmp_done = 1'b0;
    total++; if (slot_busy !== 16'h0) $display("FAIL b2b_busy_clr got %h want 0000", slot_busy); else passed++;
  endtask

  task automatic test_dual_done();
    dma_ready = 1'b1;
    set_in(1'b1, 8'h02, 4'd6, 48'h6000); tick();
    set_in(1'b0, 8'h00, 4'd0, '0);
    tick(); tick();
    total++; if (slot_busy !== 16'h0040) $display("FAIL dual_busy got %h want 0040", slot_busy); else passed++;
    dma_done = 1'b1; dma_done_slot = 4'd9;
    tick();
    dma_done = 1'b0;
    total++; if (slot_busy !== 16'h0040) $display("FAIL dual_spurious got %h want 0040", slot_busy); else passed++;
    dma_done = 1'b1; dma_done_slot = 4'd6;
    cmp_done = 1'b1; cmp_done_slot = 4'd6;
    tick();
    dma_done = 1'b0; cmp_done = 1'b0;
    total++; if (slot_busy !== 16'h0) $display("FAIL dual_clear got %h want 0000", slot_busy); else passed++;
    total++; if (err_illegal !== 1'b0) $display("FAIL dual_no_err got %b want 0", err_illegal); else passed++;
  endtask

  task automatic test_illegal();
    dma_ready = 1'b1;
    set_in(1'b1, 8'h7F, 4'd1, 48'h0);    tick();
    set_in(1'b1, 8'h01, 4'd1, 48'h1111); tick();   // illegal dropped here
    set_in(1'b0, 8'h00, 4'd0, '0);
    total++; if (err_illegal !== 1'b1) $display("FAIL ill_err got %b want 1", err_illegal); else passed++;
    total++; if (slot_busy !== 16'h0 || dma_valid !== 1'b0) $display("FAIL ill_no_issue got busy=%h v=%b want 0000/0", slot_busy, dma_valid); else passed++;
    tick();
    total++; if (dma_valid !== 1'b1 || dma_addr !== 48'h1111) $display("FAIL ill_load got v=%b a=%h want 1/1111", dma_valid, dma_addr); else passed++;
    total++; if (slot_busy !== 16'h0002) $display("FAIL ill_busy got %h want 0002", slot_busy); else passed++;
    dma_done = 1'b1; dma_done_slot = 4'd1;
    tick();
    dma_done = 1'b0;
    tick();
    total++; if (err_illegal !== 1'b1 || slot_busy !== 16'h0) $display("FAIL ill_sticky got err=%b busy=%h want 1/0000", err_illegal, slot_busy); else passed++;
  endtask

  task automatic test_async_reset();
    dma_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      set_in(1'b1, 8'h01, 4'(i), 48'(i + 1));
      tick();
    end
    set_in(1'b1, 8'h02, 4'd7, 48'h7);
    total++; if (in_ready !== 1'b0 || dma_valid !== 1'b1) $display("FAIL arst_pre got rdy=%b v=%b want 0/1", in_ready, dma_valid); else passed++;
    #2;
    rst_n = 1'b0;                                  // between edges
    #1;
    total++; if (dma_valid !== 1'b0 || dma_addr !== '0 || dma_opcode !== 8'h0) $display("FAIL arst_dma got v=%b a=%h op=%h want 0/0/0", dma_valid, dma_addr, dma_opcode); else passed++;
    total++; if (in_ready !== 1'b1 || idle !== 1'b1) $display("FAIL arst_ready_idle got %b/%b want 1/1", in_ready, idle); else passed++;
    total++; if (slot_busy !== 16'h0 || err_illegal !== 1'b0) $display("FAIL arst_busy_err got %h/%b want 0000/0", slot_busy, err_illegal); else passed++;
    set_in(1'b0, 8'h00, 4'd0, '0);
    tick();
    rst_n = 1'b1;
    dma_ready = 1'b1;
    tick(); tick();
    total++; if (dma_valid !== 1'b0 || idle !== 1'b1) $display("FAIL arst_discard got v=%b idle=%b want 0/1", dma_valid, idle); else passed++;
  endtask

  initial begin
    test_reset();
    test_basic_load();
    test_in_order();
    test_back_to_back();
    test_dual_done();
    test_illegal();
    test_async_reset();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
